rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Round-robin arbiter that shares one `recurse_mux` among `2**S` requesters. It registers the mux select, grants one requester at a time, and presents the selected word downstream over a valid/ready handshake. It sits between the requesting producers and the single consumer of the muxed bus. It is the sequencing companion to the purely combinational `recurse_mux`.

## Interface
Parameters:
- `S`, 2: select width; number of requesters `N = 2**S`.
- `T`, 1: data word width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  N: per-requester request, level-held until its beat is accepted.
- `lock`  in  N: per-requester burst-hold. Only present when `RR_MUX_ARB_LOCK_EN` is defined.
- `d`  in  N*T: flattened requester data; requester `i` occupies `d[i*T +: T]`.
- `grant`  out  N: one-hot grant, registered.
- `sel`  out  S: registered select driving the mux; `sel` is the index of the `grant` bit.
- `valid`  out  1: `z` holds a granted word, registered.
- `z`  out  T: muxed data, `d[sel*T +: T]`, combinational from `sel`.
- `ready`  in  1: downstream accepts `z` when `valid && ready`.

## Operation
- States:
  - IDLE: `valid=0`, `grant=0`.
  - GRANT: `valid=1`, one `grant` bit high.
- IDLE → GRANT when any `req` is high. The winner is the first set `req` bit searched upward from `ptr` with wrap-around (N-1 → 0).
  - `grant`, `sel` and `valid` are all loaded at that edge.
- GRANT holds `grant`/`sel` stable while `ready=0`. There is no timeout and no preemption.
- A transfer is `valid && ready` at a rising edge. On transfer:
  - `ptr <= sel + 1` modulo N.
  - State goes to IDLE.
- Requester contract:
  - Hold `req` and `d` stable while granted.
  - Drop `req` on the edge of its transfer unless it has another beat.
- If `req[sel]` falls while in GRANT, it is ignored. The beat stays valid until accepted.
- `ptr` is internal, S bits, and wraps naturally. The arbiter never grants an index whose `req` was low at the arbitration edge.
- Reset: `grant=0`, `sel=0`, `valid=0`, `ptr=0`, state IDLE. `z` then shows `d[0*T +: T]` but is meaningless while `valid=0`.
- `rst` during GRANT aborts the beat with no transfer. The next arbitration starts from index 0.

## Timing
- Arbitration latency: `req` sampled high at edge E → `valid`/`grant` high after E (1 cycle).
- After a transfer at edge E, state is IDLE for one cycle. The earliest next grant is at E+1.
  - Sustained throughput is 1 beat per 2 cycles without lock.
- If `ready` is already high when `valid` rises, the transfer occurs at the next edge, so a beat occupies exactly 1 GRANT cycle.
- `z` changes only when `sel` changes or the granted requester changes `d`. `d` must not change while granted.

## Configuration
- Macro: `RR_MUX_ARB_LOCK_EN`.
- Defined: the `lock` port exists. On transfer with `lock[sel]=1 && req[sel]=1`, the arbiter stays in GRANT:
  - same `sel`, `valid` stays 1, `ptr` unchanged;
  - back-to-back beats at 1 per cycle.
  - The burst ends at the first transfer where `lock[sel]=0`. The normal transfer rules then apply.
- Undefined: there is no `lock` port and every transfer returns to IDLE.

## Structure
- Package `rr_mux_arb_pkg` holds:
  - the state enum (IDLE, GRANT);
  - a function for the rotating first-set search over N bits;
  - the onehot-to-index helper.
- Sub-module: one `recurse_mux` instance with matching `S`, `T`, fed from `d` and `sel`, producing `z`.
- The FSM, `ptr` and the grant registers are local to `rr_mux_arbiter`.

## Test plan
All scenarios use S=2, T=1, with `d[0]=1`, `d[1]=0`, `d[2]=1`, `d[3]=0`.
- Reset, then `req=0000`: `valid=0`, `grant=0000`, `sel=0` held indefinitely. `rst` pulsed mid-GRANT → all outputs 0 the next cycle, `ptr=0`.
- `req=1111`, `ready=1` held, each requester dropping `req` on its transfer: grants occur in order `sel` 0,1,2,3. `z` goes 1,0,1,0, with one IDLE cycle between beats.
- `req=0100`, `ready=0` for 3 cycles then 1: `grant=0100`, `sel=2`, `z=1` stable for 4 cycles, then the transfer occurs and `ptr=3`.
- After `ptr=3`, `req=0011`: the wrap-around search grants index 0 first, then 1.
- `req[1]` dropped while `sel=1` with `ready=0`: `valid` stays 1 until `ready=1`.
- With `RR_MUX_ARB_LOCK_EN` defined: `req=1010` and `lock[1]=1` for 3 beats, with `ready=1`. Result is 3 consecutive cycles at `sel=1` with `z=0`. Then `lock[1]=0` → IDLE, and `sel=3` is granted next.

Source files
------------

// File: rtl/rr_mux_arb_pkg.sv
// Shared types and helpers for rr_mux_arbiter: FSM state enum, rotating first-set search
// and one-hot to index conversion, sized for up to 2**MaxS requesters.
package rr_mux_arb_pkg;

   localparam int unsigned MaxS = 6;
   localparam int unsigned MaxN = 1 << MaxS;

   typedef enum logic [0:0] {
      StIdle,
      StGrant
   } arb_state_e;

   // One-hot of the first set bit of vec[n-1:0], searching upward from start with wrap-around.
   function automatic logic [MaxN-1:0] rr_first_set(input logic [MaxN-1:0] vec,
                                                   input int unsigned    start,
                                                   input int unsigned    n);
      logic [MaxN-1:0] oh;
      logic            found;
      logic [MaxS-1:0] idx;
      oh    = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < MaxN; k++) begin
         if (k < n) begin
            idx = MaxS'((start + k) % n);
            if (!found && vec[idx]) begin
               oh[idx] = 1'b1;
               found   = 1'b1;
            end
         end
      end
      return oh;
   endfunction

   function automatic logic [MaxS-1:0] onehot_to_idx(input logic [MaxN-1:0] oh);
      logic [MaxS-1:0] idx;
      idx = '0;
      for (int i = 0; i < MaxN; i++) begin
         if (oh[i]) idx = idx | MaxS'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/recurse_mux.sv
// Combinational 2**S-to-1 mux of T-bit words, built as a recursive tree of 2:1 stages.
module recurse_mux #(
   parameter int unsigned S = 2,
   parameter int unsigned T = 1
) (
   input  logic [(2**S)*T-1:0] d,
   input  logic [S-1:0]        sel,
   output logic [T-1:0]        z
);

   localparam int unsigned Half = (2**S) / 2;

   if (S == 1) begin : g_leaf
      assign z = sel[0] ? d[2*T-1:T] : d[T-1:0];
   end else begin : g_node
      logic [T-1:0] z_lo;
      logic [T-1:0] z_hi;

      recurse_mux #(
         .S(S - 1),
         .T(T)
      ) u_lo (
         .d  (d[Half*T-1:0]),
         .sel(sel[S-2:0]),
         .z  (z_lo)
      );

      recurse_mux #(
         .S(S - 1),
         .T(T)
      ) u_hi (
         .d  (d[2*Half*T-1:Half*T]),
         .sel(sel[S-2:0]),
         .z  (z_hi)
      );

      assign z = sel[S-1] ? z_hi : z_lo;
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one recurse_mux among 2**S requesters over valid/ready.
// Optional burst-hold via `lock` when RR_MUX_ARB_LOCK_EN is defined.
module rr_mux_arbiter
   import rr_mux_arb_pkg::*;
#(
   parameter int unsigned S = 2,
   parameter int unsigned T = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [(2**S)-1:0]   req,
`ifdef RR_MUX_ARB_LOCK_EN
   input  logic [(2**S)-1:0]   lock,
`endif
   input  logic [(2**S)*T-1:0] d,
   output logic [(2**S)-1:0]   grant,
   output logic [S-1:0]        sel,
   output logic                valid,
   output logic [T-1:0]        z,
   input  logic                ready
);

   localparam int unsigned N = 2**S;

   arb_state_e      state_q, state_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [S-1:0]    sel_q, sel_d;
   logic [S-1:0]    ptr_q, ptr_d;
   logic [MaxN-1:0] req_ext;
   logic [MaxN-1:0] win_oh;
   logic            hold_burst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      win_oh         = rr_first_set(req_ext, 32'(ptr_q), N);
   end

`ifdef RR_MUX_ARB_LOCK_EN
   assign hold_burst = lock[sel_q] && req[sel_q];
`else
   assign hold_burst = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               state_d = StGrant;
               grant_d = N'(win_oh);
               sel_d   = S'(onehot_to_idx(win_oh));
            end
         end
         StGrant: begin
            // A locked transfer keeps the grant and the pointer for the next beat.
            if (ready && !hold_burst) begin
               state_d = StIdle;
               grant_d = '0;
               ptr_d   = sel_q + S'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      valid = (state_q == StGrant);
      grant = grant_q;
      sel   = sel_q;
   end

   recurse_mux #(
      .S(S),
      .T(T)
   ) u_mux (
      .d  (d),
      .sel(sel_q),
      .z  (z)
   );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (S=2, T=1); covers lock bursts when
// RR_MUX_ARB_LOCK_EN is defined.
module tb_rr_mux_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] lock;
   logic [3:0] d;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       valid;
   logic [0:0] z;
   logic       ready;

   int n_checks;
   int n_errors;

   rr_mux_arbiter #(
      .S(2),
      .T(1)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
`ifdef RR_MUX_ARB_LOCK_EN
      .lock (lock),
`endif
      .d    (d),
      .grant(grant),
      .sel  (sel),
      .valid(valid),
      .z    (z),
      .ready(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".valid"}, 32'(valid), 32'd0);
      chk({tag, ".grant"}, 32'(grant), 32'd0);
   endtask

   task automatic chk_grant(input string tag, input int idx);
      logic [3:0] oh;
      logic       exp_z;
      oh    = 4'b0001 << idx;
      exp_z = d[idx];
      chk({tag, ".valid"}, 32'(valid), 32'd1);
      chk({tag, ".grant"}, 32'(grant), 32'(oh));
      chk({tag, ".sel"},   32'(sel),   32'(idx));
      chk({tag, ".z"},     32'(z),     32'(exp_z));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      d        = 4'b0101;
      req      = 4'b0000;
      lock     = 4'b0000;
      ready    = 1'b0;
      rst      = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Idle with no requests.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle("reset_idle");
         chk("reset_idle.sel", 32'(sel), 32'd0);
      end

      // All four requesting, ready held: order 0,1,2,3 with an idle cycle between beats.
      req   = 4'b1111;
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_grant("rr_order", i);
         req[i] = 1'b0;
         tick();
         chk_idle("rr_gap");
      end

      // Single requester stalled by ready=0 for 3 cycles; pointer moves to 3.
      req   = 4'b0100;
      ready = 1'b0;
      tick();
      chk_grant("stall_first", 2);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_grant("stall_hold", 2);
      end
      ready = 1'b1;
      req   = 4'b0000;
      tick();
      chk_idle("stall_done");

      // Wrap-around from ptr=3: index 0 before 1; then drop req[1] while stalled.
      req = 4'b0011;
      tick();
      chk_grant("wrap_first", 0);
      req = 4'b0010;
      tick();
      chk_idle("wrap_gap");
      ready = 1'b0;
      tick();
      chk_grant("wrap_second", 1);
      req = 4'b0000;
      tick();
      chk_grant("req_drop_hold", 1);
      tick();
      chk_grant("req_drop_hold2", 1);
      ready = 1'b1;
      tick();
      chk_idle("req_drop_done");

      // Reset mid-grant aborts the beat and returns ptr to 0 (ptr was 2 here).
      req = 4'b1000;
      tick();
      chk_grant("pre_rst", 3);
      rst = 1'b1;
      req = 4'b0000;
      tick();
      chk_idle("mid_rst");
      chk("mid_rst.sel", 32'(sel), 32'd0);
      rst   = 1'b0;
      req   = 4'b1111;
      ready = 1'b0;
      tick();
      chk_grant("post_rst_ptr", 0);
      ready = 1'b1;
      req   = 4'b0000;
      tick();
      chk_idle("post_rst_done");

`ifdef RR_MUX_ARB_LOCK_EN
      // ptr=1: locked burst on requester 1, then release and rotate to 3.
      req   = 4'b1010;
      lock  = 4'b0010;
      ready = 1'b1;
      tick();
      chk_grant("lock_beat1", 1);
      tick();
      chk_grant("lock_beat2", 1);
      tick();
      chk_grant("lock_beat3", 1);
      lock = 4'b0000;
      tick();
      chk_idle("lock_release");
      req = 4'b1000;
      tick();
      chk_grant("lock_next", 3);
      req = 4'b0000;
      tick();
      chk_idle("lock_done");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
